// File: rtl/voice_mixer_if.sv
// Beat input, sample output and status signals of the voice mixer.
// The signal names match the block's original port names.
interface voice_mixer_if;
  logic               i_AmpValid;
  logic signed [15:0] i_Amplitude;
  logic        [15:0] i_Level;
  logic               i_FrameStart;
  logic signed [15:0] o_Sample;
  logic               o_SampleValid;
  logic               i_SampleReady;
  logic               o_Clipped;
  logic               o_Overrun;
  logic               o_SyncError;

  modport master (
    output i_AmpValid, i_Amplitude, i_Level, i_FrameStart, i_SampleReady,
    input  o_Sample, o_SampleValid, o_Clipped, o_Overrun, o_SyncError
  );

  modport slave (
    input  i_AmpValid, i_Amplitude, i_Level, i_FrameStart, i_SampleReady,
    output o_Sample, o_SampleValid, o_Clipped, o_Overrun, o_SyncError
  );
endinterface

// File: rtl/voice_mixer.sv
// Voice mixer: scales each operator amplitude by its envelope level, sums one frame of
// NUM_SLOTS beats, saturates the total to 16 bits and offers it on a valid/ready output.
module voice_mixer #(
  parameter int NUM_SLOTS = 32,
  parameter int ACC_W     = 16 + $clog2(NUM_SLOTS)
) (
  input logic          i_Clock,
  input logic          i_Reset_n,
  voice_mixer_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_SLOTS);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_SLOTS - 1);

  logic        [CNT_W-1:0]   slot_cnt;
  logic signed [32:0]        product;
  logic                      beat_first, beat_last, sync_err;
  logic                      s1_valid, s1_first, s1_last;
  logic signed [15:0]        s1_scaled;
  logic signed [ACC_W-1:0]   acc, acc_ext;
  logic                      s2_done;
  logic        [ACC_W-16:0]  acc_upper;
  logic                      in_range;
  logic signed [15:0]        sat_value;
  logic                      s3_valid, s3_clip;
  logic signed [15:0]        s3_sample;

  assign product    = 33'(bus.i_Amplitude) * 33'($signed({1'b0, bus.i_Level}));
  assign sync_err   = bus.i_AmpValid && bus.i_FrameStart && (slot_cnt != '0);
  assign beat_first = (slot_cnt == '0) || bus.i_FrameStart;
  // A resynchronising beat restarts the frame, so it can never close one.
  assign beat_last  = (slot_cnt == LAST_SLOT) && !bus.i_FrameStart;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      slot_cnt        <= '0;
      s1_valid        <= 1'b0;
      s1_first        <= 1'b0;
      s1_last         <= 1'b0;
      s1_scaled       <= '0;
      bus.o_SyncError <= 1'b0;
    end else begin
      s1_valid        <= bus.i_AmpValid;
      bus.o_SyncError <= sync_err;
      if (bus.i_AmpValid) begin
        s1_scaled <= 16'(product >>> 16);
        s1_first  <= beat_first;
        s1_last   <= beat_last;
        if (bus.i_FrameStart)
          slot_cnt <= CNT_W'(1);
        else if (slot_cnt == LAST_SLOT)
          slot_cnt <= '0;
        else
          slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  assign acc_ext = {{(ACC_W-16){s1_scaled[15]}}, s1_scaled};

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      acc     <= '0;
      s2_done <= 1'b0;
    end else begin
      s2_done <= s1_valid && s1_last;
      if (s1_valid)
        acc <= s1_first ? acc_ext : acc + acc_ext;
    end
  end

  // The total fits 16 bits exactly when every bit from 15 upward matches the sign.
  assign acc_upper = acc[ACC_W-1:15];
  assign in_range  = (acc_upper == '0) || (acc_upper == '1);

  always_comb begin
    sat_value = acc[15:0];
    if (!in_range)
      sat_value = acc[ACC_W-1] ? 16'sh8000 : 16'sh7FFF;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      s3_valid  <= 1'b0;
      s3_sample <= '0;
      s3_clip   <= 1'b0;
    end else begin
      s3_valid <= s2_done;
      if (s2_done) begin
        s3_sample <= sat_value;
        s3_clip   <= !in_range;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      bus.o_Sample      <= '0;
      bus.o_SampleValid <= 1'b0;
      bus.o_Clipped     <= 1'b0;
      bus.o_Overrun     <= 1'b0;
    end else if (s3_valid) begin
      if (!bus.o_SampleValid || bus.i_SampleReady) begin
        bus.o_Sample      <= s3_sample;
        bus.o_Clipped     <= s3_clip;
        bus.o_SampleValid <= 1'b1;
      end else begin
        bus.o_Overrun <= 1'b1;
      end
    end else if (bus.o_SampleValid && bus.i_SampleReady) begin
      bus.o_SampleValid <= 1'b0;
      bus.o_Clipped     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer with four slots per frame: directed frames checked against
// hand-computed samples and against a frame-sum model compared on every cycle.
module tb_voice_mixer;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  voice_mixer_if vif();
  voice_mixer #(.NUM_SLOTS(N)) dut (.i_Clock(clk), .i_Reset_n(rst_n), .bus(vif));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each beat contributes floor(amp*level/65536); a frame is NUM_SLOTS beats
  // starting at FrameStart or after a completed frame; its clamped sum appears 3 edges later.
  function automatic int scale(input logic signed [15:0] a, input logic [15:0] l);
    longint p, r;
    p = longint'(a) * longint'(l);
    r = p / 65536;
    if (p < 0 && (p % 65536) != 0) r = r - 1;
    return int'(r);
  endfunction

  bit          m_started = 0;
  int          m_beats = 0, m_sum = 0, m_edge = 0, m_idx;
  bit          m_ov = 0, m_oc = 0, m_ovr = 0, m_sync = 0;
  logic [15:0] m_os = '0;
  bit          pend_v[8];
  logic [15:0] pend_s[8];
  bit          pend_c[8];

  always @(posedge clk) begin
    m_started = 1;
    if (!rst_n) begin
      m_beats = 0; m_sum = 0;
      m_ov = 0; m_oc = 0; m_ovr = 0; m_sync = 0; m_os = '0;
      for (int i = 0; i < 8; i++) pend_v[i] = 0;
    end else begin
      m_idx  = m_edge % 8;
      m_sync = 0;
      if (pend_v[m_idx]) begin
        if (!m_ov || vif.i_SampleReady) begin
          m_ov = 1; m_os = pend_s[m_idx]; m_oc = pend_c[m_idx];
        end else begin
          m_ovr = 1;
        end
        pend_v[m_idx] = 0;
      end else if (m_ov && vif.i_SampleReady) begin
        m_ov = 0;
      end
      if (vif.i_AmpValid) begin
        if (vif.i_FrameStart || m_beats == 0) begin
          if (vif.i_FrameStart && m_beats != 0) m_sync = 1;
          m_sum   = scale(vif.i_Amplitude, vif.i_Level);
          m_beats = 1;
        end else begin
          m_sum   = m_sum + scale(vif.i_Amplitude, vif.i_Level);
          m_beats = m_beats + 1;
        end
        if (m_beats == N) begin
          m_idx = (m_edge + 3) % 8;
          pend_v[m_idx] = 1;
          if (m_sum > 32767)       begin pend_s[m_idx] = 16'h7FFF; pend_c[m_idx] = 1; end
          else if (m_sum < -32768) begin pend_s[m_idx] = 16'h8000; pend_c[m_idx] = 1; end
          else                     begin pend_s[m_idx] = 16'(m_sum); pend_c[m_idx] = 0; end
          m_beats = 0;
        end
      end
    end
    m_edge++;
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("model_valid", 16'(vif.o_SampleValid), 16'(m_ov));
      check("model_overrun", 16'(vif.o_Overrun), 16'(m_ovr));
      check("model_syncerr", 16'(vif.o_SyncError), 16'(m_sync));
      if (m_ov) begin
        check("model_sample", vif.o_Sample, m_os);
        check("model_clipped", 16'(vif.o_Clipped), 16'(m_oc));
      end
    end
  end

  task automatic beat(input logic [15:0] a, input logic [15:0] l, input bit fs);
    vif.i_AmpValid   = 1'b1;
    vif.i_Amplitude  = a;
    vif.i_Level      = l;
    vif.i_FrameStart = fs;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    vif.i_AmpValid   = 1'b0;
    vif.i_FrameStart = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] l);
    beat(a, l, 1'b1);
    repeat (N - 1) beat(a, l, 1'b0);
  endtask

  task automatic wait_valid(input string name, input logic [15:0] es, input bit ec);
    int n = 0;
    idle(0);
    while (!vif.o_SampleValid && n < 10) begin @(posedge clk); #1; n++; end
    if (!vif.o_SampleValid) begin
      checks++; errors++;
      $display("FAIL %s: got no valid sample within 10 cycles, expected 0x%0h", name, es);
    end else begin
      check({name, "_sample"}, vif.o_Sample, es);
      check({name, "_clip"}, 16'(vif.o_Clipped), 16'(ec));
    end
    idle(1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_sample"}, vif.o_Sample, 16'h0000);
    check({name, "_valid"}, 16'(vif.o_SampleValid), 16'h0);
    check({name, "_clip"}, 16'(vif.o_Clipped), 16'h0);
    check({name, "_ovr"}, 16'(vif.o_Overrun), 16'h0);
    check({name, "_sync"}, 16'(vif.o_SyncError), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vif.i_AmpValid = 1'b0; vif.i_Amplitude = '0; vif.i_Level = '0;
    vif.i_FrameStart = 1'b0; vif.i_SampleReady = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // 4 x 8192 = 32768 saturates high
    frame(16'h4000, 16'h8000);
    wait_valid("sat_high", 16'h7FFF, 1'b1);

    // 4 x -8192 = -32768 is exactly representable
    frame(16'hC000, 16'h8000);
    wait_valid("neg_full", 16'h8000, 1'b0);
    beat(16'h4000, 16'h8000, 1'b1);
    beat(16'h4000, 16'h8000, 1'b0);
    beat(16'h4000, 16'h8000, 1'b0);
    beat(16'h0000, 16'h8000, 1'b0);
    wait_valid("three_q", 16'h6000, 1'b0);

    // 32767*65535 >> 16 = 32766; valid exactly 3 edges after the last beat
    beat(16'h7FFF, 16'hFFFF, 1'b1);
    repeat (3) beat(16'h0000, 16'hFFFF, 1'b0);
    idle(2);
    check("latency_early", 16'(vif.o_SampleValid), 16'h0);
    idle(1);
    check("latency_valid", 16'(vif.o_SampleValid), 16'h1);
    check("latency_sample", vif.o_Sample, 16'h7FFE);
    idle(2);

    // Consumer stalls across two frames: first held, second dropped
    vif.i_SampleReady = 1'b0;
    frame(16'h4000, 16'h8000);
    frame(16'hC000, 16'h8000);
    idle(6);
    check("stall_valid", 16'(vif.o_SampleValid), 16'h1);
    check("stall_sample", vif.o_Sample, 16'h7FFF);
    check("stall_clip", 16'(vif.o_Clipped), 16'h1);
    check("stall_ovr", 16'(vif.o_Overrun), 16'h1);
    vif.i_SampleReady = 1'b1;
    idle(1);
    check("drain_valid", 16'(vif.o_SampleValid), 16'h0);
    check("drain_ovr", 16'(vif.o_Overrun), 16'h1);
    idle(2);

    // FrameStart on the 3rd beat restarts the frame; sample = 4 x 2048
    beat(16'h4000, 16'h8000, 1'b1);
    beat(16'h4000, 16'h8000, 1'b0);
    beat(16'h1000, 16'h8000, 1'b1);
    check("sync_pulse", 16'(vif.o_SyncError), 16'h1);
    beat(16'h1000, 16'h8000, 1'b0);
    check("sync_clear", 16'(vif.o_SyncError), 16'h0);
    beat(16'h1000, 16'h8000, 1'b0);
    beat(16'h1000, 16'h8000, 1'b0);
    wait_valid("sync_frame", 16'h2000, 1'b0);

    // Back-to-back frames: 4 x 2048 then 4 x 4096
    beat(16'h1000, 16'h8000, 1'b1);
    repeat (3) beat(16'h1000, 16'h8000, 1'b0);
    beat(16'h2000, 16'h8000, 1'b1);
    beat(16'h2000, 16'h8000, 1'b0);
    beat(16'h2000, 16'h8000, 1'b0);
    check("b2b_first_valid", 16'(vif.o_SampleValid), 16'h1);
    check("b2b_first_sample", vif.o_Sample, 16'h2000);
    beat(16'h2000, 16'h8000, 1'b0);
    wait_valid("b2b_second", 16'h4000, 1'b0);

    // Reset mid-frame, then a gapped frame without FrameStart: 4 x -16384 saturates low
    beat(16'h4000, 16'h8000, 1'b1);
    beat(16'h4000, 16'h8000, 1'b0);
    idle(0);
    rst_n = 1'b0;
    idle(1);
    check_all_zero("midreset");
    rst_n = 1'b1;
    beat(16'hC000, 16'hFFFF, 1'b0);
    idle(2);
    beat(16'hC000, 16'hFFFF, 1'b0);
    idle(1);
    beat(16'hC000, 16'hFFFF, 1'b0);
    idle(1);
    beat(16'hC000, 16'hFFFF, 1'b0);
    wait_valid("post_reset", 16'h8000, 1'b1);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 Parameter NUM_SLOTS, default 32, SHALL set the operator slots per audio frame (power of two, 2..64).
REQ-002 Parameter ACC_W, default 16+log2(NUM_SLOTS), SHALL set the accumulator width in bits.
REQ-003 i_Clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_Reset_n  in  1  SHALL be a synchronous, active-low reset.
REQ-005 i_AmpValid  in  1  SHALL mark a valid operator amplitude beat.
REQ-006 i_Amplitude  in  16 signed  SHALL carry the waveform generator output amplitude.
REQ-007 i_Level  in  16 unsigned  SHALL carry the envelope level aligned with i_Amplitude.
REQ-008 i_FrameStart  in  1  SHALL mark slot 0 of a frame; it is qualified by i_AmpValid.
REQ-009 o_Sample  out  16 signed  SHALL carry the mixed, saturated frame sample.
REQ-010 o_SampleValid  out  1  SHALL flag that o_Sample holds an unconsumed sample.
REQ-011 i_SampleReady  in  1  SHALL be the consumer's acceptance; a transfer occurs when valid and ready are both high.
REQ-012 o_Clipped  out  1  SHALL be high while the held sample was saturated.
REQ-013 o_Overrun  out  1  SHALL be a sticky flag set when a completed frame is dropped.
REQ-014 o_SyncError  out  1  SHALL be a one-cycle pulse on a mid-frame i_FrameStart.

Function
REQ-015 Stage 1 SHALL register scaled = (i_Amplitude * i_Level) >>> 16, computed as a 33-bit signed product with an arithmetic shift and truncated to 16-bit signed, together with valid, first and last flags.
REQ-016 The slot counter SHALL advance only on i_AmpValid, and SHALL wrap from NUM_SLOTS-1 to 0.
REQ-017 A beat SHALL be last when the counter equals NUM_SLOTS-1.
REQ-018 A beat SHALL be first when the counter equals 0 or i_FrameStart is high.
REQ-019 If i_FrameStart is high with i_AmpValid while the counter is not 0, the block SHALL pulse o_SyncError and force the counter to 1; this beat SHALL become slot 0 and the partial frame SHALL be discarded.
REQ-020 Stage 2 SHALL load the accumulator with the sign-extended scaled value on a first beat, and SHALL add the sign-extended scaled value to it otherwise.
REQ-021 The ACC_W-bit accumulator SHALL NOT overflow internally.
REQ-022 Stage 3 SHALL compute the frame total on a last beat and saturate it to [-32768, 32767]; o_Clipped SHALL equal 1 iff saturation occurred.
REQ-023 Stage 3 SHALL load the saturated total into the output register.
REQ-024 Latency: the last-slot beat sampled at edge t SHALL make o_SampleValid high after edge t+3.
REQ-025 Beats without i_AmpValid SHALL NOT alter the counter, the accumulator or the pipeline valid flags.
REQ-026 o_SampleValid SHALL clear after a transfer edge unless a new frame loads on the same edge, in which case it SHALL stay high with the new sample.
REQ-027 If a frame completes while o_SampleValid=1 and i_SampleReady=0, the new frame SHALL be dropped, o_Sample and o_Clipped SHALL be held, and o_Overrun SHALL be set.
REQ-028 o_Sample SHALL remain stable while o_SampleValid=1 and i_SampleReady=0.
REQ-029 With NUM_SLOTS beats per frame and i_SampleReady tied high, the block SHALL sustain back-to-back frames with no bubbles.

Reset
REQ-030 When i_Reset_n=0 at an edge, the block SHALL clear the counter, the accumulator and all pipeline valids.
REQ-031 During reset, o_Sample SHALL be 0x0000, and o_SampleValid, o_Clipped, o_Overrun and o_SyncError SHALL be 0.
REQ-032 A frame in progress at reset SHALL be discarded, and the first beat after reset SHALL be slot 0.

Verification (NUM_SLOTS=4)
REQ-033 Four beats of amp 0x4000, level 0x8000, ready=1 -> o_Sample=0x7FFF, o_Clipped=1 (sum 32768 saturates).
REQ-034 Four beats of amp 0xC000, level 0x8000 -> o_Sample=0x8000, o_Clipped=0; then beats of 0x4000,0x4000,0x4000,0x0000 at level 0x8000 -> 0x6000.
REQ-035 Amp 0x7FFF, level 0xFFFF, then three beats of amp 0 -> o_Sample=0x7FFE, valid 3 cycles after the 4th beat.
REQ-036 ready=0 across two full frames -> first sample held, o_Overrun=1; a ready pulse then transfers the first sample and valid drops.
REQ-037 i_FrameStart on the 3rd beat of a frame -> o_SyncError pulse, and a sample after 3 more beats containing only the 4 post-sync beats.
REQ-038 Reset asserted mid-frame after 2 beats -> all outputs 0, and the next 4 beats produce one correct sample.
